// File: rtl/id_stage_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and EX.
// The master side feeds instructions and consumes the bundle; the slave side
// is the decode stage itself.
interface id_stage_if;
  // Fetch side
  logic        in_valid;
  logic [31:0] instr;
  logic        in_ready;
  logic        flush;

  // EX side
  logic        out_valid;
  logic        out_ready;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic [63:0] imm;
  logic        alu_src;
  logic [3:0]  alu_op;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [4:0]  rd;
  logic        illegal;

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, rs1_val, rs2_val, imm, alu_src, alu_op,
           branch, mem_read, mem_write, reg_write, rd, illegal
  );

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, rs1_val, rs2_val, imm, alu_src, alu_op,
           branch, mem_read, mem_write, reg_write, rd, illegal
  );
endinterface

// File: rtl/id_stage.sv
// RV64I instruction decode stage: 32x64 register file with writeback bypass,
// instruction decoder and a single registered output bundle with a
// valid/ready handshake toward EX. Flush drops both held and incoming work.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  id_stage_if.slave   bus
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_BNE  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operation shared by register and immediate forms; alt selects SUB/SRA.
  function automatic logic [3:0] funct_to_alu(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic signed [63:0] imm_i(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic signed [63:0] imm_s(input logic [31:0] ins);
    return {{52{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic signed [63:0] imm_b(input logic [31:0] ins);
    return {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  // Register file storage
  logic [63:0] rf_q [32];

  // Output bundle registers
  logic               out_valid_q;
  logic        [63:0] rs1_val_q, rs2_val_q;
  logic signed [63:0] imm_q;
  logic               alu_src_q;
  logic        [3:0]  alu_op_q;
  logic               branch_q, mem_read_q, mem_write_q, reg_write_q;
  logic        [4:0]  rd_q;
  logic               illegal_q;

  // Decoded next bundle
  logic        [63:0] rs1_val_d, rs2_val_d;
  logic signed [63:0] imm_d;
  logic               alu_src_d;
  logic        [3:0]  alu_op_d;
  logic               branch_d, mem_read_d, mem_write_d, reg_write_d;
  logic        [4:0]  rd_d;
  logic               illegal_d;

  logic        [6:0]  opcode;
  logic        [2:0]  funct3;
  logic        [6:0]  funct7;
  logic        [4:0]  rs1_idx, rs2_idx;
  logic               in_ready;
  logic               accept;

  assign opcode  = bus.instr[6:0];
  assign funct3  = bus.instr[14:12];
  assign funct7  = bus.instr[31:25];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  // Operand read with same-cycle writeback bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_val_d = 64'd0;
    rs2_val_d = 64'd0;
    if (rs1_idx != 5'd0) begin
      if (wb_en && (wb_rd == rs1_idx)) rs1_val_d = wb_data;
      else                             rs1_val_d = rf_q[rs1_idx];
    end
    if (rs2_idx != 5'd0) begin
      if (wb_en && (wb_rd == rs2_idx)) rs2_val_d = wb_data;
      else                             rs2_val_d = rf_q[rs2_idx];
    end
  end

  // Instruction decode; any unsupported encoding collapses to an all-zero
  // control bundle with only the illegal flag raised.
  always_comb begin
    alu_op_d    = ALU_AND;
    alu_src_d   = 1'b0;
    branch_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    rd_d        = 5'd0;
    imm_d       = '0;
    illegal_d   = 1'b0;

    case (opcode)
      OPC_OP: begin
        // Only funct7 = 0, or 0100000 paired with SUB/SRA, is valid.
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          alu_op_d    = funct_to_alu(funct3, funct7[5]);
          reg_write_d = 1'b1;
          rd_d        = bus.instr[11:7];
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        // Shifts carry a 6-bit shamt; the upper bits select logical/arith.
        if (((funct3 == 3'b001) && (bus.instr[31:26] != 6'b000000)) ||
            ((funct3 == 3'b101) && (bus.instr[31:26] != 6'b000000) &&
             (bus.instr[31:26] != 6'b010000))) begin
          illegal_d = 1'b1;
        end else begin
          // ADDI ignores bit 30 because there is no SUBI.
          alu_op_d    = funct_to_alu(funct3, (funct3 == 3'b101) && bus.instr[30]);
          alu_src_d   = 1'b1;
          reg_write_d = 1'b1;
          rd_d        = bus.instr[11:7];
          imm_d       = imm_i(bus.instr);
        end
      end
      OPC_LOAD: begin
        if (funct3 != 3'b111) begin
          alu_op_d    = ALU_ADD;
          alu_src_d   = 1'b1;
          mem_read_d  = 1'b1;
          reg_write_d = 1'b1;
          rd_d        = bus.instr[11:7];
          imm_d       = imm_i(bus.instr);
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_STORE: begin
        if (!funct3[2]) begin
          alu_op_d    = ALU_ADD;
          alu_src_d   = 1'b1;
          mem_write_d = 1'b1;
          imm_d       = imm_s(bus.instr);
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000) begin
          alu_op_d = ALU_BEQ;
          branch_d = 1'b1;
          imm_d    = imm_b(bus.instr);
        end else if (funct3 == 3'b001) begin
          alu_op_d = ALU_BNE;
          branch_d = 1'b1;
          imm_d    = imm_b(bus.instr);
        end else begin
          illegal_d = 1'b1;
        end
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Register file write; runs independent of stall and flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 64'd0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Output bundle: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs1_val_q   <= 64'd0;
      rs2_val_q   <= 64'd0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= ALU_AND;
      branch_q    <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_op_q    <= alu_op_d;
      branch_q    <= branch_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      illegal_q   <= illegal_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.rs1_val   = rs1_val_q;
  assign bus.rs2_val   = rs2_val_q;
  assign bus.imm       = imm_q;
  assign bus.alu_src   = alu_src_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.branch    = branch_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.reg_write = reg_write_q;
  assign bus.rd        = rd_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode of each instruction class,
// writeback bypass, x0 handling, stall/backpressure, flush, rf reset.
module tb_id_stage;
  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  id_stage_if bus();

  id_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_en   (wb_en),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    wb_en         = 1'b0;
    wb_rd         = 5'd0;
    wb_data       = 64'd0;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held two cycles
    tick;
    chk("rst1_out_valid", 64'(bus.out_valid), 64'd0);
    tick;
    chk("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_rs1_val",   bus.rs1_val, 64'd0);
    chk("rst2_alu_op",    64'(bus.alu_op), 64'd0);
    chk("rst2_imm",       bus.imm, 64'd0);
    rst_n = 1'b1;
    tick;
    chk("rel_in_ready",   64'(bus.in_ready), 64'd1);
    chk("rel_out_valid",  64'(bus.out_valid), 64'd0);

    // Write x5 = 0x10, then addi x6,x5,-3
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h10;
    tick;
    wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.instr = 32'hFFD28313;
    tick;
    chk("addi_out_valid", 64'(bus.out_valid), 64'd1);
    chk("addi_rs1",       bus.rs1_val, 64'h10);
    chk("addi_imm",       bus.imm, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("addi_alu_src",   64'(bus.alu_src), 64'd1);
    chk("addi_alu_op",    64'(bus.alu_op), 64'b0010);
    chk("addi_rd",        64'(bus.rd), 64'd6);
    chk("addi_reg_write", 64'(bus.reg_write), 64'd1);
    chk("addi_illegal",   64'(bus.illegal), 64'd0);

    // Same-cycle writeback x7 = 0xAB with sub x8,x7,x0 (bypass)
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hAB;
    bus.instr = 32'h40038433;
    tick;
    chk("sub_out_valid",  64'(bus.out_valid), 64'd1);
    chk("sub_rs1",        bus.rs1_val, 64'hAB);
    chk("sub_rs2",        bus.rs2_val, 64'd0);
    chk("sub_alu_op",     64'(bus.alu_op), 64'b0110);
    chk("sub_alu_src",    64'(bus.alu_src), 64'd0);
    chk("sub_rd",         64'(bus.rd), 64'd8);

    // Stall three cycles with add x9,x7,x5 waiting; write x10 during stall
    bus.out_ready = 1'b0;
    bus.instr = 32'h005384B3;
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 64'h1234;
    #1;
    chk("stall_in_ready0", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      wb_en = 1'b0;
      #1;
      chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_rd",        64'(bus.rd), 64'd8);
      chk("stall_alu_op",    64'(bus.alu_op), 64'b0110);
      chk("stall_rs1",       bus.rs1_val, 64'hAB);
      chk("stall_in_ready",  64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 64'(bus.in_ready), 64'd1);
    tick;
    chk("add_out_valid",  64'(bus.out_valid), 64'd1);
    chk("add_rd",         64'(bus.rd), 64'd9);
    chk("add_rs1",        bus.rs1_val, 64'hAB);
    chk("add_rs2",        bus.rs2_val, 64'h10);
    chk("add_alu_op",     64'(bus.alu_op), 64'b0010);
    bus.in_valid = 1'b0;
    tick;
    chk("nodup_out_valid", 64'(bus.out_valid), 64'd0);

    // Write to x0 alongside add x12,x0,x10: x0 must stay zero
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
    bus.in_valid = 1'b1; bus.instr = 32'h00A00633;
    tick;
    wb_en = 1'b0;
    chk("x0_rs1",         bus.rs1_val, 64'd0);
    chk("x0_rs2_x10",     bus.rs2_val, 64'h1234);
    chk("x0_rd",          64'(bus.rd), 64'd12);

    // Illegal opcode
    bus.instr = 32'h0000007F;
    tick;
    chk("ill_out_valid",  64'(bus.out_valid), 64'd1);
    chk("ill_illegal",    64'(bus.illegal), 64'd1);
    chk("ill_reg_write",  64'(bus.reg_write), 64'd0);
    chk("ill_alu_op",     64'(bus.alu_op), 64'd0);
    chk("ill_rs1",        bus.rs1_val, 64'd0);

    // sd x5,-8(x7)
    bus.instr = 32'hFE53BC23;
    tick;
    chk("sd_imm",         bus.imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("sd_mem_write",   64'(bus.mem_write), 64'd1);
    chk("sd_rd",          64'(bus.rd), 64'd0);
    chk("sd_reg_write",   64'(bus.reg_write), 64'd0);
    chk("sd_alu_op",      64'(bus.alu_op), 64'b0010);
    chk("sd_alu_src",     64'(bus.alu_src), 64'd1);
    chk("sd_rs1",         bus.rs1_val, 64'hAB);
    chk("sd_rs2",         bus.rs2_val, 64'h10);

    // bne x5,x7,+16
    bus.instr = 32'h00729863;
    tick;
    chk("bne_alu_op",     64'(bus.alu_op), 64'b1011);
    chk("bne_branch",     64'(bus.branch), 64'd1);
    chk("bne_imm",        bus.imm, 64'd16);
    chk("bne_alu_src",    64'(bus.alu_src), 64'd0);
    chk("bne_reg_write",  64'(bus.reg_write), 64'd0);
    chk("bne_rs2",        bus.rs2_val, 64'hAB);

    // beq x0,x0,-4
    bus.instr = 32'hFE000EE3;
    tick;
    chk("beq_alu_op",     64'(bus.alu_op), 64'b1010);
    chk("beq_imm",        bus.imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_illegal",    64'(bus.illegal), 64'd0);

    // ld x13,8(x10)
    bus.instr = 32'h00853683;
    tick;
    chk("ld_mem_read",    64'(bus.mem_read), 64'd1);
    chk("ld_imm",         bus.imm, 64'd8);
    chk("ld_rs1",         bus.rs1_val, 64'h1234);
    chk("ld_rd",          64'(bus.rd), 64'd13);
    chk("ld_alu_op",      64'(bus.alu_op), 64'b0010);
    chk("ld_reg_write",   64'(bus.reg_write), 64'd1);

    // srai x14,x5,3
    bus.instr = 32'h4032D713;
    tick;
    chk("srai_alu_op",    64'(bus.alu_op), 64'b0101);
    chk("srai_imm",       bus.imm, 64'h403);
    chk("srai_alu_src",   64'(bus.alu_src), 64'd1);
    chk("srai_rs1",       bus.rs1_val, 64'h10);

    // Flush while a bundle is held and another is offered; x15 written anyway
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    bus.instr = 32'h00078093;
    wb_en = 1'b1; wb_rd = 5'd15; wb_data = 64'h99;
    tick;
    wb_en = 1'b0;
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick;
    chk("flush_no_issue",  64'(bus.out_valid), 64'd0);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    tick;
    chk("flush_drop_in",   64'(bus.out_valid), 64'd0);

    // addi x1,x15,0 sees value written during flush
    bus.flush = 1'b0;
    tick;
    chk("x15_out_valid",  64'(bus.out_valid), 64'd1);
    chk("x15_rs1",        bus.rs1_val, 64'h99);
    chk("x15_rd",         64'(bus.rd), 64'd1);

    // Reset mid-stream clears bundle and register file
    rst_n = 1'b0; bus.in_valid = 1'b0;
    tick;
    chk("rst3_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst3_rd",        64'(bus.rd), 64'd0);
    chk("rst3_rs1",       bus.rs1_val, 64'd0);
    chk("rst3_reg_write", 64'(bus.reg_write), 64'd0);
    rst_n = 1'b1;
    tick;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    chk("rfclr_out_valid", 64'(bus.out_valid), 64'd1);
    chk("rfclr_rs1",       bus.rs1_val, 64'd0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
